// File: rtl/video_timer_prog.sv
// Programmable video timing generator: pixel-enabled x/y counters, sync/visible decodes,
// line/frame strobes, frame counter, and a frame-boundary-applied shadow config.
// Ports: clk, rst (async active-low), pix_ce, cfg_* valid/ready handshake with timing fields,
// cfg_pending/cfg_err status, hsync/vsync/visible, position_*, line_start/frame_start, frame.
module video_timer_prog #(
  parameter int CNT_W     = 12,
  parameter int FRAME_W   = 32,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_h_visible,
  input  logic [CNT_W-1:0]   cfg_h_front,
  input  logic [CNT_W-1:0]   cfg_h_sync,
  input  logic [CNT_W-1:0]   cfg_h_back,
  input  logic [CNT_W-1:0]   cfg_v_visible,
  input  logic [CNT_W-1:0]   cfg_v_front,
  input  logic [CNT_W-1:0]   cfg_v_sync,
  input  logic [CNT_W-1:0]   cfg_v_back,
  input  logic               cfg_hsync_pol,
  input  logic               cfg_vsync_pol,
  output logic               cfg_pending,
  output logic               cfg_err,
  output logic               hsync,
  output logic               vsync,
  output logic               visible,
  output logic [CNT_W-1:0]   position_x,
  output logic [CNT_W-1:0]   position_y,
  output logic [CNT_W-1:0]   position_x_next,
  output logic [CNT_W-1:0]   position_y_next,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame
);

  localparam int SW = CNT_W + 2;

  typedef struct packed {
    logic [CNT_W-1:0] hv;
    logic [CNT_W-1:0] hf;
    logic [CNT_W-1:0] hs;
    logic [CNT_W-1:0] hb;
    logic [CNT_W-1:0] vv;
    logic [CNT_W-1:0] vf;
    logic [CNT_W-1:0] vs;
    logic [CNT_W-1:0] vb;
    logic             hp;
    logic             vp;
  } cfg_t;

  localparam cfg_t DEF = '{
    hv: CNT_W'(H_VISIBLE), hf: CNT_W'(H_FRONT),
    hs: CNT_W'(H_SYNC),    hb: CNT_W'(H_BACK),
    vv: CNT_W'(V_VISIBLE), vf: CNT_W'(V_FRONT),
    vs: CNT_W'(V_SYNC),    vb: CNT_W'(V_BACK),
    hp: HSYNC_POL,         vp: VSYNC_POL
  };

  localparam logic [CNT_W-1:0] X_RST =
    CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] Y_RST =
    CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] TOT_MAX = SW'(1) << CNT_W;

  function automatic logic [SW-1:0] sum4(
    input logic [CNT_W-1:0] a,
    input logic [CNT_W-1:0] b,
    input logic [CNT_W-1:0] c,
    input logic [CNT_W-1:0] d
  );
    return SW'(a) + SW'(b) + SW'(c) + SW'(d);
  endfunction

  cfg_t act_q, act_d;
  cfg_t shd_q, shd_d;
  cfg_t req;

  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic [FRAME_W-1:0] fr_q, fr_d;
  logic pend_q, pend_d;
  logic rdy_q, rdy_d;
  logic err_q, err_d;
  logic ls_q, ls_d;
  logic fs_q, fs_d;

  logic [SW-1:0] h_tot, v_tot;
  logic [SW-1:0] rq_h_tot, rq_v_tot;
  logic [SW-1:0] hs_lo, hs_hi, vs_lo, vs_hi;
  logic [SW-1:0] x_w, y_w;
  logic [CNT_W-1:0] x_nx, y_nx;
  logic x_last, y_last, wrap;
  logic acc, req_ok;
  logic hs_on, vs_on;

  assign req = '{
    hv: cfg_h_visible, hf: cfg_h_front,
    hs: cfg_h_sync,    hb: cfg_h_back,
    vv: cfg_v_visible, vf: cfg_v_front,
    vs: cfg_v_sync,    vb: cfg_v_back,
    hp: cfg_hsync_pol, vp: cfg_vsync_pol
  };

  assign h_tot = sum4(act_q.hv, act_q.hf,
                      act_q.hs, act_q.hb);
  assign v_tot = sum4(act_q.vv, act_q.vf,
                      act_q.vs, act_q.vb);
  assign rq_h_tot = sum4(req.hv, req.hf,
                         req.hs, req.hb);
  assign rq_v_tot = sum4(req.vv, req.vf,
                         req.vs, req.vb);

  assign req_ok = (req.hv != '0) && (req.hf != '0)
               && (req.hs != '0) && (req.hb != '0)
               && (req.vv != '0) && (req.vf != '0)
               && (req.vs != '0) && (req.vb != '0)
               && (rq_h_tot <= TOT_MAX)
               && (rq_v_tot <= TOT_MAX);

  assign x_w    = SW'(x_q);
  assign y_w    = SW'(y_q);
  assign x_last = (x_w == h_tot - SW'(1));
  assign y_last = (y_w == v_tot - SW'(1));

  // y only moves when x wraps, so the next-position view mirrors that
  assign x_nx = x_last ? '0 : x_q + CNT_W'(1);
  assign y_nx = !x_last ? y_q :
                y_last  ? '0  : y_q + CNT_W'(1);

  assign wrap = pix_ce && x_last && y_last;
  assign acc  = cfg_valid && rdy_q;

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    // apply and accept are exclusive: accept needs ready, ready means not pending
    if (wrap && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
    if (acc && req_ok) begin
      shd_d  = req;
      pend_d = 1'b1;
    end
    rdy_d = !pend_d;
    err_d = acc && !req_ok;
    ls_d  = pix_ce && x_last;
    fs_d  = wrap;
    x_d   = pix_ce ? x_nx : x_q;
    y_d   = pix_ce ? y_nx : y_q;
    fr_d  = wrap ? fr_q + FRAME_W'(1) : fr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_q  <= DEF;
      shd_q  <= DEF;
      x_q    <= X_RST;
      y_q    <= Y_RST;
      fr_q   <= '1;
      pend_q <= 1'b0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      ls_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fr_q   <= fr_d;
      pend_q <= pend_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      ls_q   <= ls_d;
      fs_q   <= fs_d;
    end
  end

  assign hs_lo = SW'(act_q.hv) + SW'(act_q.hf);
  assign hs_hi = hs_lo + SW'(act_q.hs);
  assign vs_lo = SW'(act_q.vv) + SW'(act_q.vf);
  assign vs_hi = vs_lo + SW'(act_q.vs);

  assign hs_on = (x_w >= hs_lo) && (x_w < hs_hi);
  assign vs_on = (y_w >= vs_lo) && (y_w < vs_hi);

  assign hsync   = hs_on ? act_q.hp : ~act_q.hp;
  assign vsync   = vs_on ? act_q.vp : ~act_q.vp;
  assign visible = (x_q < act_q.hv) && (y_q < act_q.vv);

  assign position_x      = x_q;
  assign position_y      = y_q;
  assign position_x_next = x_nx;
  assign position_y_next = y_nx;
  assign line_start      = ls_q;
  assign frame_start     = fs_q;
  assign frame           = fr_q;
  assign cfg_pending     = pend_q;
  assign cfg_ready       = rdy_q;
  assign cfg_err         = err_q;

endmodule

// File: tb/tb_video_timer_prog.sv
// Bench for video_timer_prog: small default timing, scoreboard of
// expected per-cycle outputs from a behavioural model.
module tb_video_timer_prog;

  localparam int HV = 8, HF = 2, HS = 3, HB = 4;
  localparam int VV = 4, VF = 1, VS = 2, VB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_ce = 1'b0;
  logic cfg_valid = 1'b0;
  logic [11:0] c [8];
  logic chp = 1'b0, cvp = 1'b0;

  logic cfg_ready, cfg_pending, cfg_err;
  logic hsync, vsync, visible;
  logic [11:0] position_x, position_y;
  logic [11:0] position_x_next, position_y_next;
  logic line_start, frame_start;
  logic [31:0] frame;

  video_timer_prog #(
    .CNT_W(12), .FRAME_W(32),
    .H_VISIBLE(HV), .H_FRONT(HF),
    .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF),
    .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_h_visible(c[0]), .cfg_h_front(c[1]),
    .cfg_h_sync(c[2]), .cfg_h_back(c[3]),
    .cfg_v_visible(c[4]), .cfg_v_front(c[5]),
    .cfg_v_sync(c[6]), .cfg_v_back(c[7]),
    .cfg_hsync_pol(chp), .cfg_vsync_pol(cvp),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .hsync(hsync), .vsync(vsync), .visible(visible),
    .position_x(position_x), .position_y(position_y),
    .position_x_next(position_x_next),
    .position_y_next(position_y_next),
    .line_start(line_start), .frame_start(frame_start),
    .frame(frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] x, y, xn, yn;
    logic hs, vs, vis, ls, fs;
    logic [31:0] fr;
    logic pend, rdy, err;
  } obs_t;

  obs_t q[$];
  int errors = 0;
  int checks = 0;

  int act[8], shd[8];
  bit ahp, avp, shp, svp;
  int mx, my;
  logic [31:0] mfr;
  bit mpend, mrdy, merr, mls, mfs;

  task automatic model_reset();
    act = '{HV, HF, HS, HB, VV, VF, VS, VB};
    shd = act;
    ahp = 0; avp = 0; shp = 0; svp = 0;
    mx = HV + HF + HS;
    my = VV + VF + VS;
    mfr = 32'hffff_ffff;
    mpend = 0; mrdy = 0; merr = 0;
    mls = 0; mfs = 0;
  endtask

  task automatic model_edge(input bit pce, input bit cv);
    int ht, vt, ch, cvt;
    bit acc, ok, xw, yw;
    ht = act[0] + act[1] + act[2] + act[3];
    vt = act[4] + act[5] + act[6] + act[7];
    ch = int'(c[0]) + int'(c[1]) + int'(c[2]) + int'(c[3]);
    cvt = int'(c[4]) + int'(c[5]) + int'(c[6]) + int'(c[7]);
    acc = cv && mrdy;
    ok = 1;
    foreach (c[i]) if (c[i] == 12'd0) ok = 0;
    if (ch > 4096 || cvt > 4096) ok = 0;
    xw = (mx == ht - 1);
    yw = (my == vt - 1);
    mls = pce && xw;
    mfs = pce && xw && yw;
    merr = acc && !ok;
    if (mfs && mpend) begin
      act = shd; ahp = shp; avp = svp; mpend = 0;
    end
    if (acc && ok) begin
      foreach (c[i]) shd[i] = int'(c[i]);
      shp = chp; svp = cvp; mpend = 1;
    end
    mrdy = !mpend;
    if (pce) begin
      if (xw) begin
        mx = 0;
        my = yw ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    if (mfs) mfr = mfr + 32'd1;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    int ht, vt;
    bit xw;
    ht = act[0] + act[1] + act[2] + act[3];
    vt = act[4] + act[5] + act[6] + act[7];
    xw = (mx == ht - 1);
    o.x = 12'(mx);
    o.y = 12'(my);
    o.xn = xw ? 12'd0 : 12'(mx + 1);
    o.yn = !xw ? 12'(my) : (my == vt - 1) ? 12'd0 : 12'(my + 1);
    o.hs = ((mx >= act[0] + act[1]) &&
            (mx < act[0] + act[1] + act[2])) ? ahp : !ahp;
    o.vs = ((my >= act[4] + act[5]) &&
            (my < act[4] + act[5] + act[6])) ? avp : !avp;
    o.vis = (mx < act[0]) && (my < act[4]);
    o.ls = mls;
    o.fs = mfs;
    o.fr = mfr;
    o.pend = mpend;
    o.rdy = mrdy;
    o.err = merr;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = position_x;
    o.y = position_y;
    o.xn = position_x_next;
    o.yn = position_y_next;
    o.hs = hsync;
    o.vs = vsync;
    o.vis = visible;
    o.ls = line_start;
    o.fs = frame_start;
    o.fr = frame;
    o.pend = cfg_pending;
    o.rdy = cfg_ready;
    o.err = cfg_err;
    return o;
  endfunction

  task automatic set_cfg(input int v[8], input bit hp, input bit vp);
    foreach (c[i]) c[i] = 12'(v[i]);
    chp = hp;
    cvp = vp;
  endtask

  task automatic step(input bit pce, input bit cv);
    pix_ce = pce;
    cfg_valid = cv;
    model_edge(pce, cv);
    q.push_back(model_obs());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t e;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    q.push_back(model_obs());
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", dut_obs(), e);
    end
    rst = 1'b1;
    step(0, 0);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", dut_obs(), e);
    end
  endtask

  task automatic test_free_run();
    obs_t e;
    int last_fs = -1, last_ls = -1, nfs = 0;
    for (int i = 0; i < 360; i++) begin
      step(1, 0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) begin
        errors++;
        $display("FAIL free_run cyc=%0d got=%h exp=%h", i, dut_obs(), e);
      end
      if (line_start) begin
        if (last_ls >= 0) begin
          checks++;
          if (i - last_ls != 17) begin
            errors++;
            $display("FAIL line_period got=%0d exp=17", i - last_ls);
          end
        end
        last_ls = i;
      end
      if (frame_start) begin
        nfs++;
        if (nfs == 1) begin
          checks++;
          if (frame !== 32'd0) begin
            errors++;
            $display("FAIL first_frame got=%h exp=0", frame);
          end
        end else begin
          checks++;
          if (i - last_fs != 170) begin
            errors++;
            $display("FAIL frame_period got=%0d exp=170", i - last_fs);
          end
        end
        last_fs = i;
      end
    end
    checks++;
    if (nfs != 2) begin
      errors++;
      $display("FAIL frame_count got=%0d exp=2", nfs);
    end
  endtask

  task automatic test_pix_ce();
    obs_t e;
    int last_ls = -1;
    for (int i = 0; i < 400; i++) begin
      step(i % 4 == 0, 0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) begin
        errors++;
        $display("FAIL pix_ce cyc=%0d got=%h exp=%h", i, dut_obs(), e);
      end
      if (line_start) begin
        if (last_ls >= 0) begin
          checks++;
          if (i - last_ls != 68) begin
            errors++;
            $display("FAIL ce_line_period got=%0d exp=68", i - last_ls);
          end
        end
        last_ls = i;
      end
    end
  endtask

  task automatic test_cfg_apply();
    obs_t e;
    int last_ls = -1;
    set_cfg('{6, 1, 2, 3, 3, 1, 1, 2}, 1, 1);
    step(1, 1);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e || cfg_pending !== 1'b1 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL cfg_accept got=%h exp=%h", dut_obs(), e);
    end
    for (int i = 0; i < 400; i++) begin
      step(1, 0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) begin
        errors++;
        $display("FAIL cfg_apply cyc=%0d got=%h exp=%h", i, dut_obs(), e);
      end
      if (line_start) last_ls = i;
    end
    checks++;
    if (cfg_pending !== 1'b0 || last_ls < 0) begin
      errors++;
      $display("FAIL cfg_applied pending=%b exp=0", cfg_pending);
    end
  endtask

  task automatic test_cfg_err();
    obs_t e;
    set_cfg('{6, 1, 0, 3, 3, 1, 1, 2}, 0, 0);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) set_cfg('{4000, 400, 400, 200, 3, 1, 1, 2}, 0, 0);
      step(1, 1);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e || cfg_err !== 1'b1 || cfg_pending !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err k=%0d got=%h exp=%h", k, dut_obs(), e);
      end
      step(1, 0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e || cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_pulse k=%0d got=%h exp=%h", k, dut_obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int nacc = 0;
    bit seen = 0;
    set_cfg('{HV, HF, HS, HB, VV, VF, VS, VB}, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!seen && cfg_ready) nacc++;
      step(1, 1);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, dut_obs(), e);
      end
      if (frame_start) seen = 1;
    end
    checks++;
    if (!seen || nacc != 1) begin
      errors++;
      $display("FAIL single_accept got=%0d exp=1", nacc);
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    int n = 0;
    while (!cfg_ready && n < 400) begin
      step(1, 0);
      void'(q.pop_front());
      n++;
    end
    checks++;
    if (!cfg_ready) begin
      errors++;
      $display("FAIL ready_timeout got=0 exp=1");
    end
    set_cfg('{6, 1, 2, 3, 3, 1, 1, 2}, 1, 1);
    step(1, 1);
    void'(q.pop_front());
    step(1, 0);
    void'(q.pop_front());
    step(1, 0);
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e || cfg_pending !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got=%h exp=%h", dut_obs(), e);
    end
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    q.push_back(model_obs());
    e = q.pop_front();
    checks++;
    if (dut_obs() !== e) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", dut_obs(), e);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step(1, 0);
      e = q.pop_front();
      checks++;
      if (dut_obs() !== e) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", i, dut_obs(), e);
      end
      if (i == 0) begin
        checks++;
        if (position_x !== 12'd14 || position_y !== 12'd7) begin
          errors++;
          $display("FAIL resume_pos got=%0d,%0d exp=14,7", position_x, position_y);
        end
      end
    end
  endtask

  initial begin
    set_cfg('{HV, HF, HS, HB, VV, VF, VS, VB}, 0, 0);
    test_reset();
    test_free_run();
    test_pix_ce();
    test_cfg_apply();
    test_cfg_err();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_timer_prog.md
Name: video_timer_prog

Overview:
- Runtime-programmable, pixel-clock-enabled successor to the fixed-mode video timer.
- Generates hsync/vsync/visible, pixel coordinates, line/frame strobes and a frame counter.
- Timing and sync polarity are set from a config port. New settings are held in a shadow register and applied only on a frame boundary, so mode switches never tear a frame.
- Sits between the system clock domain and the pixel pipeline. It is clocked at system rate and advances on pix_ce.

Parameters:
- CNT_W, 12: width of the x/y counters and of every cfg timing field.
- FRAME_W, 32: width of the frame counter.
- H_VISIBLE, H_FRONT, H_SYNC, H_BACK: defaults 640, 16, 96, 48. Horizontal timing in effect after reset.
- V_VISIBLE, V_FRONT, V_SYNC, V_BACK: defaults 480, 10, 2, 33. Vertical timing in effect after reset.
- HSYNC_POL, VSYNC_POL: defaults 0, 0. Sync active level after reset (0 = active-low).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low: the block is held in reset while rst==0.
- pix_ce  in  1  pixel enable; timing advances only on cycles with pix_ce==1.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- cfg_h_visible, cfg_h_front, cfg_h_sync, cfg_h_back  in  CNT_W each  horizontal timing.
- cfg_v_visible, cfg_v_front, cfg_v_sync, cfg_v_back  in  CNT_W each  vertical timing.
- cfg_hsync_pol, cfg_vsync_pol  in  1 each  sync active level.
- cfg_pending  out  1  shadow config waiting for frame boundary.
- cfg_err  out  1  one-cycle pulse: request rejected.
- hsync, vsync  out  1 each  sync outputs, polarity applied.
- visible  out  1  x and y both in the visible region.
- position_x, position_y  out  CNT_W each  current counters.
- position_x_next, position_y_next  out  CNT_W each  counter values after the next pix_ce.
- line_start, frame_start  out  1 each  strobes.
- frame  out  FRAME_W  frame counter.

Behaviour:

Reset (rst==0, asynchronous):
- Active config = parameters.
- x = H_VISIBLE+H_FRONT+H_SYNC (start of back porch); y = V_VISIBLE+V_FRONT+V_SYNC.
- frame = all ones.
- cfg_pending = 0, cfg_ready = 0, cfg_err = 0, line_start = 0, frame_start = 0, visible = 0.
- hsync and vsync are at their inactive level (= ~active polarity).
- cfg_ready = 1 from the first cycle after rst deasserts.

Counters:
- h_total = sum of the 4 h fields; v_total likewise. Sums are computed in CNT_W+2 bits.
- On pix_ce: x_next = (x==h_total-1) ? 0 : x+1.
- y advances only when x wraps: y_next = (y==v_total-1) ? 0 : y+1.
- Without pix_ce, all state holds. position_*_next = the value x/y will take at the next pix_ce.
- position_x and position_y are full CNT_W with no truncation. They equal x and y, valid in all regions.

Decodes (combinational from registered x/y and active config):
- visible = (x < h_visible) && (y < v_visible).
- hsync is active when h_visible+h_front <= x < h_visible+h_front+h_sync. vsync is the equivalent vertical decode.

Strobes (registered, one cycle wide, asserted on the edge where the counter moves):
- line_start = 1 on the edge where x becomes 0.
- frame_start = 1 on the edge where (x,y) becomes (0,0). frame increments on that same edge. The first frame after reset is 0.

Config handshake:
- A transfer is accepted when cfg_valid && cfg_ready.
- Validation: every field must be nonzero, and each total must be <= 2^CNT_W.
  - Invalid: cfg_err pulses on the next cycle; the shadow is unchanged; the active config is unchanged.
  - Valid: the shadow is loaded, cfg_pending = 1, cfg_ready = 0.
- Apply: on the edge where (x,y) wraps to (0,0), the shadow becomes active and cfg_pending clears. cfg_ready = 1 the following cycle.
- The new config takes effect for the frame starting at that wrap; the decodes for (0,0) use the new values.
- If an accept and a wrap fall on the same edge, the accept is not possible because cfg_ready==0 while pending. An accept with no pending config, coinciding with a wrap, is applied at the next wrap, not the current one.
- If the new totals are smaller than the current x/y, this cannot occur: the apply happens only at (0,0).

Reset mid-operation:
- Immediate return to the reset state.
- The shadow is discarded and the parameter config restored.

Test Plan:
- Reset, then pix_ce=1 constantly, default params:
  - first hsync low at x=656..751, with 800 clocks per line and 525 lines per frame;
  - frame goes ffffffff->0 at the first (0,0);
  - frame_start pulses every 420000 cycles.
- pix_ce asserted every 4th cycle -> all periods scale by 4; position, sync and strobes are frozen on cycles with pix_ce=0.
- Mid-frame, load 800x600 (40/128/88, 1/4/23) with pol=1 -> cfg_pending=1 and cfg_ready=0 until the wrap. The next frame has 1056 clocks/line, 628 lines and active-high syncs; the current frame is unchanged.
- Config with cfg_h_sync=0, or with h total 5000 at CNT_W=12 -> cfg_err pulses 1 cycle; no pending; timing unchanged.
- Drop rst to 0 while a config is pending and mid-line -> outputs are at reset values in the same cycle. After release, default 640x480 resumes from x=752, y=492.
- cfg_valid held through the pending window -> exactly one accept. A second accept occurs only after the wrap, and is applied at the following wrap.
